column_scanner: RTL

- Self-timed column driver for the LED matrix display.
- Owns the column counter internally and walks a one-hot column enable across N_COLS columns.
- Inserts a programmable blanking gap between columns to suppress ghosting.
- Emits a column strobe and a frame-start pulse so the row-data path can latch the pattern for the upcoming column.

---
 rtl/column_scanner_if.sv | 34 +++
 rtl/column_scanner.sv | 120 ++++++++++++
 2 files changed

// File: rtl/column_scanner_if.sv
// Column scanner bus: scan enable in, column drive and row-latch timing out.
//   en          scan enable (from controller)
//   cols        one-hot column enables
//   col_idx     index of the current or upcoming column
//   col_strobe  one-cycle pulse on the first blank cycle of every column
//   frame_start col_strobe for column 0
// master: the scanner. slave: the controller / row-data path.
interface column_scanner_if #(
  parameter int unsigned N_COLS = 5
);
  localparam int unsigned IDX_W = (N_COLS > 1) ? $clog2(N_COLS) : 1;

  logic              en;
  logic [N_COLS-1:0] cols;
  logic [IDX_W-1:0]  col_idx;
  logic              col_strobe;
  logic              frame_start;

  modport master (
    input  en,
    output cols,
    output col_idx,
    output col_strobe,
    output frame_start
  );

  modport slave (
    output en,
    input  cols,
    input  col_idx,
    input  col_strobe,
    input  frame_start
  );
endinterface

// File: rtl/column_scanner.sv
// Self-timed LED matrix column driver. Walks a one-hot column enable across N_COLS
// columns with BLANK_CYC all-off cycles ahead of DRIVE_CYC drive cycles per column.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    column_scanner_if.master (en in; cols, col_idx, col_strobe, frame_start out)
// All outputs are registered.
// Build option: define COLUMN_SCANNER_ACTIVE_LOW_EN for active-low cols
// (inactive/reset all 1s, driven bit 0).
module column_scanner #(
  parameter int unsigned N_COLS    = 5,
  parameter int unsigned BLANK_CYC = 2,
  parameter int unsigned DRIVE_CYC = 4
) (
  input logic                clk,
  input logic                rst_n,
  column_scanner_if.master   bus
);
  localparam int unsigned IDX_W   = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int unsigned MAX_CYC = (BLANK_CYC > DRIVE_CYC) ? BLANK_CYC : DRIVE_CYC;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_COLS - 1);

`ifdef COLUMN_SCANNER_ACTIVE_LOW_EN
  localparam logic [N_COLS-1:0] COLS_OFF = '1;
`else
  localparam logic [N_COLS-1:0] COLS_OFF = '0;
`endif

  typedef enum logic [1:0] {StIdle, StBlank, StDrive} state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic [N_COLS-1:0] cols_q;
  logic              strobe_q;
  logic              frame_q;

  logic              idx_wrap;
  logic [IDX_W-1:0]  idx_inc;
  logic [N_COLS-1:0] col_sel;

  always_comb begin
    idx_wrap = (idx_q == IDX_LAST);
    idx_inc  = idx_wrap ? '0 : idx_q + IDX_W'(1);
    col_sel  = N_COLS'(1) << idx_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      cols_q   <= COLS_OFF;
      strobe_q <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      // Strobes are single-cycle: only the transition into BLANK raises them.
      strobe_q <= 1'b0;
      frame_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.en) begin
            state_q  <= StBlank;
            cnt_q    <= '0;
            idx_q    <= '0;
            cols_q   <= COLS_OFF;
            strobe_q <= 1'b1;
            frame_q  <= 1'b1;
          end
        end
        StBlank: begin
          if (!bus.en) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            cols_q  <= COLS_OFF;
          end else if (cnt_q == BLANK_LAST) begin
            state_q <= StDrive;
            cnt_q   <= '0;
            cols_q  <= COLS_OFF ^ col_sel;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StDrive: begin
          if (!bus.en) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            cols_q  <= COLS_OFF;
          end else if (cnt_q == DRIVE_LAST) begin
            state_q  <= StBlank;
            cnt_q    <= '0;
            idx_q    <= idx_inc;
            cols_q   <= COLS_OFF;
            strobe_q <= 1'b1;
            frame_q  <= idx_wrap;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
          idx_q   <= '0;
          cols_q  <= COLS_OFF;
        end
      endcase
    end
  end

  assign bus.cols        = cols_q;
  assign bus.col_idx     = idx_q;
  assign bus.col_strobe  = strobe_q;
  assign bus.frame_start = frame_q;
endmodule
